// File: rtl/rsa_bus_master_if.sv
// Operand/result streams plus the Avalon-MM-style register bus of the RSA initiator.
interface rsa_bus_master_if;
  logic         op_valid;
  logic         op_ready;
  logic [127:0] op_data;
  logic         res_valid;
  logic         res_ready;
  logic [127:0] res_data;
  logic         chipselect;
  logic         write;
  logic [2:0]   address;
  logic [31:0]  writedata;
  logic [31:0]  readdata;

  modport master (
    input  op_valid, op_data, res_ready, readdata,
    output op_ready, res_valid, res_data, chipselect, write, address, writedata
  );

  modport slave (
    output op_valid, op_data, res_ready, readdata,
    input  op_ready, res_valid, res_data, chipselect, write, address, writedata
  );
endinterface

// File: rtl/rsa_bus_master.sv
// RSA multiplier initiator: checks the slave ID after reset, then writes a
// 128-bit operand as four words, waits out the multiply, reads the product back.
module rsa_bus_master #(
  parameter int          COMPUTE_CYCLES = 2,
  parameter int          READ_LATENCY   = 1,
  parameter bit          CHECK_ID       = 1'b1,
  parameter logic [31:0] ID_VALUE       = 32'd65537
) (
  input  logic             clk,
  input  logic             reset,
  rsa_bus_master_if.master bus,
  output logic             busy,
  output logic             id_err
);
  localparam int MAX_WAIT = (COMPUTE_CYCLES > READ_LATENCY) ? COMPUTE_CYCLES : READ_LATENCY;
  localparam int WAIT_W   = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam logic [WAIT_W-1:0] CMP_LAST = WAIT_W'(COMPUTE_CYCLES - 1);
  localparam logic [WAIT_W-1:0] RD_LAST  = WAIT_W'(READ_LATENCY - 1);

  typedef enum logic [3:0] {
    S_ID_RD, S_ID_WAIT, S_ERROR, S_IDLE, S_WR, S_COMPUTE, S_RD, S_RD_WAIT, S_DONE
  } state_e;

  localparam state_e RST_STATE = CHECK_ID ? S_ID_RD : S_IDLE;

  state_e              state_q, state_d;
  logic [1:0]          k_q, k_d;
  logic [WAIT_W-1:0]   wcnt_q, wcnt_d;
  logic [127:0]        op_q, op_d;
  logic [127:0]        res_q, res_d;
  logic                id_err_q, id_err_d;

  logic                cs_c, wr_c, op_rdy_c, res_vld_c, busy_c;
  logic [2:0]          addr_c;
  logic [31:0]         wdata_c;

  // State, counters, operand/result registers and sticky ID error flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= RST_STATE;
      k_q      <= '0;
      wcnt_q   <= '0;
      op_q     <= '0;
      res_q    <= '0;
      id_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      wcnt_q   <= wcnt_d;
      op_q     <= op_d;
      res_q    <= res_d;
      id_err_q <= id_err_d;
    end
  end

  // Next-state and bus/stream outputs; bus fields stay 0 outside an access cycle
  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    wcnt_d    = wcnt_q;
    op_d      = op_q;
    res_d     = res_q;
    id_err_d  = id_err_q;
    cs_c      = 1'b0;
    wr_c      = 1'b0;
    addr_c    = '0;
    wdata_c   = '0;
    op_rdy_c  = 1'b0;
    res_vld_c = 1'b0;
    unique case (state_q)
      S_ID_RD: begin
        cs_c    = 1'b1;
        addr_c  = 3'd4;
        wcnt_d  = '0;
        state_d = S_ID_WAIT;
      end
      S_ID_WAIT: begin
        if (wcnt_q == RD_LAST) begin
          if (bus.readdata == ID_VALUE) begin
            state_d = S_IDLE;
          end else begin
            id_err_d = 1'b1;
            state_d  = S_ERROR;
          end
        end else begin
          wcnt_d = wcnt_q + 1'b1;
        end
      end
      S_ERROR: begin
        state_d = S_ERROR;
      end
      S_IDLE: begin
        op_rdy_c = 1'b1;
        if (bus.op_valid) begin
          op_d    = bus.op_data;
          k_d     = '0;
          state_d = S_WR;
        end
      end
      S_WR: begin
        cs_c    = 1'b1;
        wr_c    = 1'b1;
        addr_c  = {1'b0, k_q};
        wdata_c = op_q[32*k_q +: 32];
        if (k_q == 2'd3) begin
          wcnt_d  = '0;
          state_d = S_COMPUTE;
        end else begin
          k_d = k_q + 2'd1;
        end
      end
      S_COMPUTE: begin
        if (wcnt_q == CMP_LAST) begin
          k_d     = '0;
          state_d = S_RD;
        end else begin
          wcnt_d = wcnt_q + 1'b1;
        end
      end
      S_RD: begin
        cs_c    = 1'b1;
        addr_c  = {1'b0, k_q};
        wcnt_d  = '0;
        state_d = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        if (wcnt_q == RD_LAST) begin
          res_d[32*k_q +: 32] = bus.readdata;
          if (k_q == 2'd3) begin
            state_d = S_DONE;
          end else begin
            k_d     = k_q + 2'd1;
            state_d = S_RD;
          end
        end else begin
          wcnt_d = wcnt_q + 1'b1;
        end
      end
      S_DONE: begin
        res_vld_c = 1'b1;
        if (bus.res_ready) state_d = S_IDLE;
      end
      default: state_d = RST_STATE;
    endcase
  end

  assign busy_c = !(state_q inside {S_IDLE, S_ERROR});

  // Everything is forced low while reset is held so an aborted access drops at once
  assign bus.chipselect = reset & cs_c;
  assign bus.write      = reset & wr_c;
  assign bus.address    = reset ? addr_c : 3'd0;
  assign bus.writedata  = reset ? wdata_c : 32'd0;
  assign bus.op_ready   = reset & op_rdy_c;
  assign bus.res_valid  = reset & res_vld_c;
  assign bus.res_data   = res_q;
  assign busy           = reset & busy_c;
  assign id_err         = id_err_q;
endmodule

// File: tb/tb_rsa_bus_master.sv
// Bench for rsa_bus_master: multiplier slave model, bus monitor, vector table,
// random operands against a 128-bit arithmetic reference, reset/ID corner cases.
module tb_rsa_bus_master;
  localparam int CC  = 2;
  localparam int RL  = 1;
  localparam int LAT = 4 + CC + 4 * (1 + RL) + 1;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic        busy, id_err;
  logic [31:0] id_word = 32'd65537;
  int          cyc = 0;
  int          n_chk = 0, n_pass = 0;

  rsa_bus_master_if bus();

  rsa_bus_master #(
    .COMPUTE_CYCLES(CC), .READ_LATENCY(RL), .CHECK_ID(1'b1), .ID_VALUE(32'd65537)
  ) dut (
    .clk(clk), .reset(rst_n), .bus(bus), .busy(busy), .id_err(id_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Slave: word registers, product computed when address 3 is written, registered reads
  logic [31:0]  wreg [4];
  logic [127:0] prod = '0;
  always @(posedge clk) begin
    if (bus.chipselect && bus.write) begin
      wreg[bus.address[1:0]] <= bus.writedata;
      if (bus.address == 3'd3)
        prod <= 128'({wreg[1], wreg[0]}) * 128'({bus.writedata, wreg[2]});
    end
    if (bus.chipselect && !bus.write)
      bus.readdata <= (bus.address == 3'd4) ? id_word : prod[32*bus.address[1:0] +: 32];
  end

  // Bus monitor: every access cycle with the cycle index it happened in
  typedef struct packed {
    logic        wr;
    logic [2:0]  addr;
    logic [31:0] data;
    logic [31:0] c;
  } acc_t;
  acc_t acc_q[$];
  always @(negedge clk)
    if (bus.chipselect)
      acc_q.push_back(acc_t'{bus.write, bus.address, bus.writedata, 32'(cyc)});

  typedef struct {
    logic [127:0] op;
    logic [127:0] exp;
    int           hold;
    bit           pre;
  } vec_t;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", nm, act, exp);
  endtask

  task automatic release_reset();
    @(posedge clk);
    #2;
    acc_q.delete();
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // One full transaction; starts and ends at a negedge
  task automatic run_op(input logic [127:0] op, input logic [127:0] exp, input int hold,
                        input bit pre, input bit keep, output int acc_c, output int hs_c);
    int n;
    bit ok;
    logic [127:0] first;
    op_valid_drv(1'b1, op);
    bus.res_ready = pre;
    n = 0;
    while (!bus.op_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("accept", {127'd0, bus.op_ready}, 128'd1);
    acc_c = cyc + 1;
    @(negedge clk);
    bus.op_data = ~op;  // garbage while busy must be ignored
    n  = 1;
    ok = 1'b1;
    while (!bus.res_valid && n < 100) begin
      if (bus.op_ready || !busy) ok = 1'b0;
      @(negedge clk);
      n++;
    end
    if (bus.op_ready || !busy) ok = 1'b0;
    chk("busy_no_accept", ok, 1);
    chk("latency", n, LAT);
    chk("res_data", bus.res_data, exp);
    first = bus.res_data;
    if (!pre && hold > 0) begin
      ok = 1'b1;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        if (!bus.res_valid || bus.res_data !== first || bus.op_ready) ok = 1'b0;
      end
      chk("done_hold", ok, 1);
    end
    bus.res_ready = 1'b1;
    hs_c = cyc + 1;
    @(negedge clk);
    bus.res_ready = 1'b0;
    if (!keep) bus.op_valid = 1'b0;
    chk("post_hs", {bus.res_valid, bus.op_ready}, 2'b01);
    chk("bus_count", acc_q.size(), 8);
    for (int k = 0; k < 8 && acc_q.size() > 0; k++) begin
      acc_t a, e;
      a = acc_q.pop_front();
      if (k < 4) begin
        e = acc_t'{1'b1, 3'(k), op[32*k +: 32], 32'(acc_c + k)};
      end else begin
        a.data = '0;
        e = acc_t'{1'b0, 3'(k - 4), 32'd0, 32'(acc_c + 4 + CC + (k - 4) * (1 + RL))};
      end
      chk("bus_acc", a, e);
    end
  endtask

  task automatic op_valid_drv(input logic v, input logic [127:0] d);
    bus.op_valid = v;
    bus.op_data  = d;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, want $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[6];
    int   ac, hc, prev_hc;
    bit   ok;
    vt[0] = '{{64'd3, 64'd2}, 128'd6, 0, 1'b0};
    vt[1] = '{{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF},
              128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001, 10, 1'b0};
    vt[2] = '{{64'd0, 64'h1234_5678_9ABC_DEF0}, 128'd0, 0, 1'b1};
    vt[3] = '{{64'h1_0000_0000, 64'h1_0000_0000}, 128'h1_0000_0000_0000_0000, 0, 1'b1};
    vt[4] = '{{64'h10, 64'hDEAD_BEEF}, 128'hD_EADB_EEF0, 1, 1'b0};
    vt[5] = '{{64'hFFFF_FFFF_FFFF_FFFF, 64'd2}, 128'h1_FFFF_FFFF_FFFF_FFFE, 3, 1'b0};

    bus.op_valid  = 1'b0;
    bus.op_data   = '0;
    bus.res_ready = 1'b0;
    #1 rst_n = 1'b0;
    #3;
    chk("rst_outputs", {bus.chipselect, bus.write, bus.address, bus.writedata,
                        bus.op_ready, bus.res_valid, busy, id_err}, '0);
    chk("rst_res_data", bus.res_data, '0);

    // Power-up ID read
    release_reset();
    chk("id_rd", {bus.chipselect, bus.write, bus.address, busy, bus.op_ready}, 7'b1_0_100_1_0);
    @(negedge clk);
    chk("id_wait", {bus.chipselect, bus.op_ready}, 2'b00);
    @(negedge clk);
    chk("idle_after_id", {bus.op_ready, id_err, busy}, 3'b100);
    chk("id_bus_count", acc_q.size(), 1);
    acc_q.delete();

    // Directed vectors, op_valid kept high between them (back-to-back)
    prev_hc = 0;
    for (int i = 0; i < 6; i++) begin
      run_op(vt[i].op, vt[i].exp, vt[i].hold, vt[i].pre, i < 5, ac, hc);
      if (i > 0) chk("b2b_gap", ac - prev_hc, 1);
      prev_hc = hc;
    end

    // Random operands against plain 128-bit multiplication
    for (int i = 0; i < 24; i++) begin
      logic [127:0] op;
      bit kp;
      op = {$urandom, $urandom, $urandom, $urandom};
      if (i % 5 == 0) op[63:32] = '0;
      kp = ($urandom_range(0, 1) == 1) && (i < 23);
      run_op(op, 128'(op[63:0]) * 128'(op[127:64]), int'($urandom_range(0, 3)),
             $urandom_range(0, 1) == 1, kp, ac, hc);
      if (!kp) repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    // Wrong ID: sticky error, no further bus activity
    @(negedge clk);
    id_word = 32'd5;
    rst_n   = 1'b0;
    release_reset();
    op_valid_drv(1'b1, {64'd3, 64'd2});
    repeat (2) @(negedge clk);
    chk("id_err_set", {id_err, bus.op_ready, busy}, 3'b100);
    ok = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (!id_err || bus.op_ready || bus.chipselect) ok = 1'b0;
    end
    chk("error_hold", ok, 1);
    chk("error_bus_count", acc_q.size(), 1);

    // Recover, then abort with reset in the third write cycle
    id_word = 32'd65537;
    bus.op_valid = 1'b0;
    rst_n = 1'b0;
    release_reset();
    repeat (2) @(negedge clk);
    chk("id_recover", {id_err, bus.op_ready}, 2'b01);
    op_valid_drv(1'b1, {64'd7, 64'd9});
    @(negedge clk);
    bus.op_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("third_wr", {bus.chipselect, bus.write, bus.address}, 5'b1_1_010);
    #1 rst_n = 1'b0;
    #1 chk("abort_bus", {bus.chipselect, bus.address, bus.writedata, busy, bus.res_valid}, '0);
    release_reset();
    ok = 1'b1;
    repeat (30) begin
      @(negedge clk);
      if (bus.res_valid) ok = 1'b0;
    end
    chk("no_res_after_abort", ok, 1);
    chk("id_reissue", acc_q.size(), 1);
    if (acc_q.size() > 0) chk("id_reissue_addr", {acc_q[0].wr, acc_q[0].addr}, 4'b0100);
    acc_q.delete();
    run_op({64'd7, 64'd9}, 128'd63, 1, 1'b0, 1'b0, ac, hc);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/rsa_bus_master.md
Name: rsa_bus_master

Overview:
- Avalon-MM-style initiator that drives the RSA box multiplier register interface from the fabric side.
- Accepts a 128-bit operand on a valid/ready stream and writes it as four 32-bit words to addresses 0..3. The write to address 3 starts the multiply.
- Waits a fixed compute interval, reads the 128-bit product back from addresses 0..3, and returns it on a valid/ready result stream.
- After every reset it reads the ID register at address 4 and checks it before accepting any work.

Parameters:
- COMPUTE_CYCLES, 2: idle cycles between the address-3 write and the first result read; minimum 1.
- READ_LATENCY, 1: cycles from a read access cycle to the edge at which readdata is sampled; minimum 1.
- CHECK_ID, 1: 1 = perform the post-reset ID read; 0 = skip it and go straight to IDLE.
- ID_VALUE, 32'd65537: expected ID word at address 4.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- op_valid  in  1  operand valid.
- op_ready  out  1  operand accept.
- op_data  in  128  operand; [63:0] and [127:64] are the two factors.
- res_valid  out  1  result valid.
- res_ready  in  1  result accept.
- res_data  out  128  product.
- busy  out  1  high in every state except IDLE and ERROR.
- id_err  out  1  sticky ID mismatch flag.
- chipselect  out  1  bus select.
- write  out  1  1 = write, 0 = read (meaningful only when chipselect=1).
- address  out  3  word address.
- writedata  out  32  write data.
- readdata  in  32  registered read data from the slave.

Behaviour:
- Reset (async, reset=0): state ID_RD if CHECK_ID=1, else IDLE. All outputs 0; res_data, id_err and the operand register are cleared.
- One bus access is one cycle with chipselect=1. chipselect=0 in all other cycles, with address, write and writedata driven 0.
- ID_RD: read access to address 4, then ID_WAIT for READ_LATENCY cycles, sampling readdata on the last edge.
  - Match: go to IDLE.
  - Mismatch: set id_err and go to ERROR.
- ERROR: terminal until reset. op_ready=0 and no bus activity.
- IDLE: op_ready=1. On op_valid && op_ready, latch op_data and go to WR with word counter 0.
- WR: four consecutive cycles of write=1, address = counter 0..3, writedata = operand[32*k+31:32*k]. After k=3, go to COMPUTE.
- COMPUTE: count COMPUTE_CYCLES cycles with chipselect=0, then go to RD with counter 0.
- RD: one read access at address = counter, then RD_WAIT for READ_LATENCY cycles.
  - The final edge of RD_WAIT captures readdata into res_data[32*k+31:32*k].
  - k<3: return to RD with k+1. k=3: go to DONE.
- DONE: res_valid=1 with res_data held stable. On res_valid && res_ready, drop res_valid and go to IDLE.
  - op_ready rises in the cycle after the result handshake; back-to-back operands cost one IDLE cycle.
- Latency: counting the cycle after the accept edge as cycle 1, res_valid first rises in cycle 4 + COMPUTE_CYCLES + 4*(1+READ_LATENCY) + 1. This is 15 with the defaults.
- op_valid while busy: ignored (op_ready=0) and not queued.
- res_ready held high in advance: result consumed in its first DONE cycle.
- Reset asserted mid-transaction: the bus is released immediately (chipselect=0), the result is discarded, and the ID check repeats on deassert.
- Counters are 2-bit for the word index and $clog2-sized for the wait counts. No wrap beyond their terminal values.

Test Plan:
- Power-up with a slave model returning 65537 at address 4 -> one read to address 4, then op_ready=1 and id_err=0 after 1+READ_LATENCY cycles.
- Slave model returns 32'd5 at address 4 -> id_err=1, op_ready stays 0, no further chipselect, both held until reset.
- op_data = {64'd3, 64'd2} with the slave multiplier model -> writes 2,0,3,0 to addresses 0..3 on consecutive cycles; reads at addresses 0..3; res_data=128'd6 with res_valid rising in cycle 15.
- op_data = {64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF}, res_ready=0 for 10 cycles -> res_data=128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001 held stable; op_ready=0 until the cycle after res_ready=1.
- op_valid held high for two operands -> the second is accepted exactly one cycle after the first result handshake; no bus access overlaps.
- reset pulsed low during the third WR cycle -> chipselect=0 in the same cycle, res_valid never asserts, ID read reissued, and a subsequent operand completes correctly.
